add_accum_pipe: RTL and testbench
=================================

ADD_ACCUM_PIPE -- requirements
Module: add_accum_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal 4..16).
REQ-002 SHALL have parameter SKID, default 0, meaning 1 = in_ready is driven from a registered skid stage, 0 = in_ready is combinational.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  the operand beat is valid.
REQ-006 SHALL have port in_ready  output  1  the block accepts the beat this cycle.
REQ-007 SHALL have port a  input  WIDTH  first operand.
REQ-008 SHALL have port b  input  WIDTH  second operand.
REQ-009 SHALL have port mode  input  2  operation: 00 ADD, 01 SUB, 10 ACC, 11 CLR.
REQ-010 SHALL have port out_valid  output  1  the result beat is valid.
REQ-011 SHALL have port out_ready  input  1  the consumer accepts the result.
REQ-012 SHALL have port sum  output  WIDTH  result.
REQ-013 SHALL have port carry  output  1  raw carry-out (ADD/ACC) or borrow (SUB) of this beat.
REQ-014 SHALL have port ovf_sticky  output  1  set by any carry/borrow since the last CLR or reset.

Function
REQ-015 SHALL be a two-stage pipeline: S1 registers a, b and mode; S2 computes and registers sum, carry and the accumulator.
REQ-016 SHALL transfer a beat on in_valid&&in_ready and on out_valid&&out_ready; no other condition transfers a beat.
REQ-017 SHALL give a latency of exactly 2 cycles from input handshake to out_valid when out_ready is held high, with throughput 1 beat/cycle.
REQ-018 SHALL have in_ready = !s1_valid || !s2_valid || out_ready when SKID=0.
REQ-019 SHALL hold sum, carry and out_valid stable while out_valid && !out_ready.
REQ-020 ADD SHALL compute a+b over WIDTH+1 bits; carry = bit WIDTH.
REQ-021 SUB SHALL compute a-b; carry = 1 iff a<b.
REQ-022 ACC SHALL compute acc+a (b ignored), then acc <= result and sum = the new acc.
REQ-023 CLR SHALL set acc <= 0, sum = 0, carry = 0 and clear ovf_sticky.
REQ-024 SHALL update acc and ovf_sticky only on the cycle the beat moves S1->S2, never while S2 is stalled.
REQ-025 ADD and SUB SHALL NOT modify acc.
REQ-026 SHALL set ovf_sticky in the same cycle a beat with carry=1 enters S2; a CLR entering S2 in that cycle clears it instead.
REQ-027 SHALL process back-to-back ACC beats with no bubble; each beat SHALL see the acc written by its predecessor.

Reset
REQ-028 On rst, SHALL clear s1_valid, s2_valid, out_valid, sum, carry, acc and ovf_sticky to 0, and set in_ready to 1 on the first cycle after rst deasserts.
REQ-029 An rst asserted mid-operation SHALL discard in-flight beats; none SHALL appear on the output.
REQ-030 rst SHALL take priority over any simultaneous handshake.

Configuration
REQ-031 Macro ADD_ACCUM_SAT_EN SHALL control saturation.
- Defined: ADD/ACC results with carry=1 saturate to all-ones; SUB results with borrow saturate to 0; acc stores the saturated value.
- Undefined: results wrap modulo 2^WIDTH.
- In both cases carry and ovf_sticky report the raw carry/borrow.

Structure
REQ-032 Package add_accum_pkg SHALL hold the mode localparams MODE_ADD, MODE_SUB, MODE_ACC and MODE_CLR, plus the 2-bit mode typedef.
REQ-033 Sub-module add_accum_stage SHALL implement one valid/ready pipeline register and SHALL be instantiated for S1 and S2.
REQ-034 The arithmetic SHALL reside in add_accum_pipe.

Verification
REQ-035 Scenario: WIDTH=8, out_ready=1, ADD a=0x7F b=0x01 -> after 2 cycles sum=0x80, carry=0, out_valid for 1 cycle.
REQ-036 Scenario: ADD a=0xFF b=0x02 -> sum=0x01 (wrap), or 0xFF with ADD_ACCUM_SAT_EN; carry=1; ovf_sticky=1.
REQ-037 Scenario: SUB a=0x03 b=0x05 -> sum=0xFE, or 0x00 with SAT_EN; carry=1.
REQ-038 Scenario: CLR, then ACC a=0x10 four beats back-to-back -> sums 0x10, 0x20, 0x30, 0x40 on consecutive cycles; ovf_sticky=0.
REQ-039 Scenario: out_ready low for 5 cycles during ACC stream -> in_ready drops after 2 beats buffered, outputs held stable, no beat lost or duplicated, acc advances exactly once per beat.
REQ-040 Scenario: rst pulsed with 2 beats in flight -> out_valid=0, acc=0, ovf_sticky=0 next cycle; next ACC a=0x01 yields sum=0x01.

Source files
------------

// File: rtl/add_accum_pkg.sv
// rtl/add_accum_pkg.sv - mode encodings and shared types for the add/accumulate pipeline
package add_accum_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_ADD = 2'b00;
  localparam mode_t MODE_SUB = 2'b01;
  localparam mode_t MODE_ACC = 2'b10;
  localparam mode_t MODE_CLR = 2'b11;

endpackage

// File: rtl/add_accum_stage.sv
// rtl/add_accum_stage.sv - one valid/ready pipeline register
module add_accum_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  // The slot may be refilled in the same cycle its occupant is taken.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/add_accum_pipe.sv
// rtl/add_accum_pipe.sv - two-stage add/sub/accumulate pipeline with sticky overflow
// ADD_ACCUM_SAT_EN selects saturating results instead of modulo wrap.
module add_accum_pipe
  import add_accum_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SKID  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  mode_t            mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf_sticky
);

  localparam int S1W = 2 * WIDTH + 2;
  localparam int S2W = WIDTH + 1;

  logic           s0_valid;
  logic           s0_ready;
  logic [S1W-1:0] s0_data;
  logic [S1W-1:0] in_data;

  assign in_data = {mode, a, b};

  generate
    if (SKID != 0) begin : g_skid
      logic           skid_valid;
      logic [S1W-1:0] skid_data;

      // in_ready is a flop: a beat accepted while S1 stalls parks here.
      always_ff @(posedge clk) begin
        if (rst) begin
          skid_valid <= 1'b0;
          skid_data  <= '0;
        end else if (skid_valid) begin
          if (s0_ready) begin
            skid_valid <= 1'b0;
          end
        end else if (in_valid && !s0_ready) begin
          skid_valid <= 1'b1;
          skid_data  <= in_data;
        end
      end

      assign in_ready = !skid_valid;
      assign s0_valid = skid_valid || in_valid;
      assign s0_data  = skid_valid ? skid_data : in_data;
    end else begin : g_direct
      assign in_ready = s0_ready;
      assign s0_valid = in_valid;
      assign s0_data  = in_data;
    end
  endgenerate

  logic           s1_valid;
  logic [S1W-1:0] s1_data;
  logic           s2_in_ready;
  logic           s2_valid;
  logic [S2W-1:0] s2_data;

  add_accum_stage #(.W(S1W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s0_valid),
    .in_ready  (s0_ready),
    .in_data   (s0_data),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_data)
  );

  mode_t            s1_mode;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH:0]   raw;
  logic [WIDTH-1:0] res;
  logic             res_c;

  assign s1_mode = mode_t'(s1_data[S1W-1 -: 2]);
  assign s1_a    = s1_data[2*WIDTH-1 -: WIDTH];
  assign s1_b    = s1_data[WIDTH-1:0];

  always_comb begin
    raw   = '0;
    res_c = 1'b0;
    case (s1_mode)
      MODE_ADD: raw = {1'b0, s1_a} + {1'b0, s1_b};
      MODE_SUB: raw = {1'b0, s1_a} - {1'b0, s1_b};
      MODE_ACC: raw = {1'b0, acc} + {1'b0, s1_a};
      default:  raw = '0;
    endcase
    // Bit WIDTH is the carry for additions and the borrow for subtraction.
    res_c = raw[WIDTH];
    res   = raw[WIDTH-1:0];
`ifdef ADD_ACCUM_SAT_EN
    if (res_c) begin
      res = (s1_mode == MODE_SUB) ? '0 : '1;
    end
`endif
  end

  add_accum_stage #(.W(S2W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   ({res_c, res}),
    .out_valid (s2_valid),
    .out_ready (out_ready),
    .out_data  (s2_data)
  );

  logic s2_load;
  assign s2_load = s1_valid && s2_in_ready;

  // Architectural state only moves with the beat, so stalls never double-count.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      ovf_sticky <= 1'b0;
    end else if (s2_load) begin
      if (s1_mode == MODE_ACC) begin
        acc <= res;
      end
      if (s1_mode == MODE_CLR) begin
        acc        <= '0;
        ovf_sticky <= 1'b0;
      end else if (res_c) begin
        ovf_sticky <= 1'b1;
      end
    end
  end

  assign out_valid = s2_valid;
  assign carry     = s2_data[WIDTH];
  assign sum       = s2_data[WIDTH-1:0];

endmodule

// File: tb/tb_add_accum_pipe.sv
// tb/tb_add_accum_pipe.sv - scoreboard bench for add_accum_pipe
module tb_add_accum_pipe;
  import add_accum_pkg::*;

  localparam int W    = 8;
  localparam int MAXV = 255;
`ifdef ADD_ACCUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry;
  logic         ovf_sticky;

  add_accum_pipe #(.WIDTH(W), .SKID(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum        (sum),
    .carry      (carry),
    .ovf_sticky (ovf_sticky)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int sum;
    int carry;
    int ovf;
    bit lat;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_acc  = 0;
  bit   m_ovf  = 1'b0;
  bit   rand_ready = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation definitions.
  task automatic push_beat(input logic [1:0] m, input int av, input int bv, input bit lat);
    exp_t e;
    int   s;
    int   c;
    s = 0;
    c = 0;
    if (m == MODE_ADD) begin
      s = av + bv;
      c = (s > MAXV) ? 1 : 0;
      if (c != 0) s = SAT ? MAXV : s - (MAXV + 1);
    end else if (m == MODE_SUB) begin
      c = (av < bv) ? 1 : 0;
      s = (c != 0) ? (SAT ? 0 : av - bv + MAXV + 1) : av - bv;
    end else if (m == MODE_ACC) begin
      s = m_acc + av;
      c = (s > MAXV) ? 1 : 0;
      if (c != 0) s = SAT ? MAXV : s - (MAXV + 1);
      m_acc = s;
    end else begin
      m_acc = 0;
    end
    if (m == MODE_CLR) m_ovf = 1'b0;
    else if (c != 0) m_ovf = 1'b1;
    e.sum   = s;
    e.carry = c;
    e.ovf   = int'(m_ovf);
    e.lat   = lat;
    e.cyc   = cyc;
    q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send(input logic [1:0] m, input int av, input int bv, input bit lat);
    int tries;
    tries    = 0;
    in_valid = 1'b1;
    mode     = m;
    a        = W'(av);
    b        = W'(bv);
    #1;
    while (!in_ready && tries < 200) begin
      tick();
      #1;
      tries++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    else push_beat(m, av, bv, lat);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic reset_seq();
    rst      = 1'b1;
    in_valid = 1'b0;
    q.delete();
    m_acc = 0;
    m_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_sum", int'(sum), 0);
    check("rst_carry", int'(carry), 0);
    check("rst_ovf", int'(ovf_sticky), 0);
    tick();
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks stall stability.
  bit         held = 1'b0;
  logic [W-1:0] h_sum;
  logic       h_carry;
  logic       h_ovf;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("hold_valid", int'(out_valid), 1);
          check("hold_sum", int'(sum), int'(h_sum));
          check("hold_carry", int'(carry), int'(h_carry));
          check("hold_ovf", int'(ovf_sticky), int'(h_ovf));
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            check("spurious_beat_count", 1, 0);
          end else begin
            e = q.pop_front();
            check("sum", int'(sum), e.sum);
            check("carry", int'(carry), e.carry);
            check("ovf_sticky", int'(ovf_sticky), e.ovf);
            if (e.lat) check("latency", cyc - e.cyc, 2);
          end
        end
        held    = out_valid && !out_ready;
        h_sum   = sum;
        h_carry = carry;
        h_ovf   = ovf_sticky;
      end
    end
  end

  initial begin
    int accepted;
    int waited;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    mode      = MODE_ADD;
    out_ready = 1'b1;
    @(negedge clk);
    reset_seq();

    send(MODE_ADD, 'h7F, 'h01, 1'b1);
    idle(3);
    send(MODE_ADD, 'hFF, 'h02, 1'b1);
    idle(3);
    send(MODE_SUB, 'h03, 'h05, 1'b1);
    idle(3);
    send(MODE_CLR, 0, 0, 1'b1);
    for (int i = 0; i < 4; i++) send(MODE_ACC, 'h10, 'h5A, 1'b1);
    idle(4);

    // Stall the consumer for 5 cycles while an ACC stream is offered.
    send(MODE_CLR, 0, 0, 1'b0);
    idle(3);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    mode      = MODE_ACC;
    a         = 8'h03;
    b         = 8'h00;
    accepted  = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (in_ready) begin
        push_beat(MODE_ACC, 3, 0, 1'b0);
        accepted++;
      end
      @(negedge clk);
    end
    #1;
    check("stall_accepted", accepted, 2);
    check("stall_in_ready", int'(in_ready), 0);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    send(MODE_ACC, 3, 0, 1'b0);
    send(MODE_ACC, 3, 0, 1'b0);
    idle(4);

    // Reset with two beats in flight; they must vanish.
    send(MODE_ACC, 'h05, 0, 1'b0);
    send(MODE_ADD, 'hFF, 'hFF, 1'b0);
    reset_seq();
    send(MODE_ACC, 'h01, 0, 1'b1);
    idle(4);

    rand_ready = 1'b1;
    for (int i = 0; i < 800; i++) begin
      send(2'($urandom_range(0, 3)), $urandom_range(0, MAXV), $urandom_range(0, MAXV), 1'b0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    rand_ready = 1'b0;
    out_ready  = 1'b1;
    in_valid   = 1'b0;
    waited     = 0;
    while (q.size() != 0 && waited < 50) begin
      tick();
      waited++;
    end
    check("drain_remaining", q.size(), 0);
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
